can_acf_multi_cu: RTL and testbench
===================================

Name: can_acf_multi_cu

Overview:
Next-generation acceptance filter control unit for the CAN controller RX path. It captures each received message from the bit-stream synchroniser and compares its identifier against NUM_FILT independently enabled ID/mask filters. Accepted messages are written to the RX FIFO with full-flag backpressure. Over the previous single-filter control unit, it adds a parametrised filter count, a lowest-index match report, a bypass mode, backpressure stalling, and saturating drop/reject counters.

Parameters:
MSG_W, 128, width of RX message word and FIFO write data
NUM_FILT, 4, number of acceptance filters (1..16)
ID_LSB, 3, bit position of ID[0] inside the message; ID field = msg[ID_LSB+28:ID_LSB]
IDE_POS, 2, bit position of the IDE flag inside the message
CNT_W, 8, width of drop and reject counters

Ports:
i_cu_sys_clk  in  1  system clock; all logic on rising edge
i_cu_reset  in  1  reset, synchronous, active-high
i_cu_syn_can_ready  in  1  one-cycle pulse: i_cu_rx_message is valid
i_cu_rx_message  in  MSG_W  received message
i_cu_rx_full  in  1  RX FIFO full
i_cu_uaf  in  NUM_FILT  per-filter enable (bit k enables filter k)
i_cu_afr_id  in  30*NUM_FILT  filter k reference {IDE, ID[28:0]} at [30k+29:30k]
i_cu_afr_mask  in  30*NUM_FILT  filter k mask; 1 = compare bit, 0 = don't care
i_cu_cnt_clr  in  1  synchronous clear of both counters
o_cu_rx_w_en  out  1  RX FIFO write strobe
o_cu_rx_fifo_w_data  out  MSG_W  FIFO write data
o_cu_acfbsy  out  1  filter busy
o_cu_match_valid  out  1  high with o_cu_rx_w_en when the write came from a filter hit
o_cu_match_idx  out  4  index of the hit filter (valid with o_cu_match_valid)
o_cu_drop_cnt  out  CNT_W  messages lost (arrived while busy)
o_cu_rej_cnt  out  CNT_W  messages rejected by all enabled filters

Behaviour:
- Reset (sync, i_cu_reset=1 at edge): state=IDLE; all outputs 0; message register 0; counters 0. Reset mid-operation aborts any pending write, and no w_en follows.
- States: IDLE, COMPARE, WRITE.
- IDLE: on i_cu_syn_can_ready=1, register the message into msg_q and go to COMPARE. o_cu_acfbsy=0.
- COMPARE (exactly 1 cycle, o_cu_acfbsy=1): sample i_cu_uaf, i_cu_afr_id and i_cu_afr_mask in this cycle only.
  - key = {msg_q[IDE_POS], msg_q[ID_LSB+28:ID_LSB]}.
  - hit_k = uaf[k] & (((key ^ id_k) & mask_k) == 0).
  - If uaf == 0 (bypass): go to WRITE with match flag 0.
  - Else if any hit_k: go to WRITE with match flag 1 and idx = lowest k with hit_k.
  - Else: rej_cnt += 1 (saturating), then go to IDLE.
- WRITE (o_cu_acfbsy=1):
  - If i_cu_rx_full=0: o_cu_rx_w_en=1 for this cycle; o_cu_match_valid = match flag; o_cu_match_idx = idx (0 otherwise); next state IDLE.
  - If i_cu_rx_full=1: hold in WRITE with w_en=0 until full deasserts. There is no timeout.
- o_cu_rx_fifo_w_data = msg_q, registered. It is stable from COMPARE through the w_en cycle and holds its value after the write.
- Latency: ready pulse at cycle t; w_en at t+2 when not full (minimum). Next message is accepted in IDLE at t+3.
- Back-to-back: an i_cu_syn_can_ready arriving in COMPARE or WRITE is discarded; drop_cnt += 1 (saturating); msg_q is unchanged.
- Counters saturate at 2^CNT_W-1.
  - i_cu_cnt_clr zeroes both counters; clear wins over a same-cycle increment.
  - Reset wins over clear.
- Multiple hits: the lowest index wins. Disabled filters never hit, even with mask = 0.
- A mask of all zeros on an enabled filter accepts every message.
- Config changes outside the COMPARE cycle do not affect an in-flight message.

Test Plan:
- Single hit: uaf=4'b0100, filter2 id={0,29'h123}, mask=all 1s; message key={0,29'h123}, full=0 -> w_en at t+2, match_valid=1, match_idx=2, w_data=message.
- Priority/don't-care: filter1 mask=0 and filter3 exact match, both enabled -> match_idx=1. Flip one key bit covered by filter3's mask -> still idx 1.
- Reject and bypass: uaf=4'b0001 with a non-matching key -> no w_en, rej_cnt=1. Then set uaf=0 and send any message -> w_en at t+2, match_valid=0.
- Backpressure: matching message with full=1 for 5 cycles -> acfbsy=1 throughout, w_en=0. Full falls at cycle t+7 -> single w_en that cycle with data unchanged.
- Drop, saturation, clear: issue a ready pulse during WRITE stall -> drop_cnt +1, original message written. Saturate drop_cnt at 255 with CNT_W=8 -> stays 255. Assert cnt_clr together with an increment -> counters read 0.
- Reset mid-write: reset asserted while in WRITE with full=1 -> next cycle all outputs 0, state IDLE. Releasing full produces no w_en.

Source files
------------

// File: rtl/can_acf_multi_cu_if.sv
// Handshake and configuration bundle between the CAN RX synchroniser/FIFO side
// and the multi-filter acceptance control unit.
interface can_acf_multi_cu_if #(
    parameter int MSG_W    = 128,
    parameter int NUM_FILT = 4,
    parameter int CNT_W    = 8
);
    logic                    i_cu_syn_can_ready;
    logic [MSG_W-1:0]        i_cu_rx_message;
    logic                    i_cu_rx_full;
    logic [NUM_FILT-1:0]     i_cu_uaf;
    logic [30*NUM_FILT-1:0]  i_cu_afr_id;
    logic [30*NUM_FILT-1:0]  i_cu_afr_mask;
    logic                    i_cu_cnt_clr;
    logic                    o_cu_rx_w_en;
    logic [MSG_W-1:0]        o_cu_rx_fifo_w_data;
    logic                    o_cu_acfbsy;
    logic                    o_cu_match_valid;
    logic [3:0]              o_cu_match_idx;
    logic [CNT_W-1:0]        o_cu_drop_cnt;
    logic [CNT_W-1:0]        o_cu_rej_cnt;

    modport slave (
        input  i_cu_syn_can_ready, i_cu_rx_message, i_cu_rx_full, i_cu_uaf,
               i_cu_afr_id, i_cu_afr_mask, i_cu_cnt_clr,
        output o_cu_rx_w_en, o_cu_rx_fifo_w_data, o_cu_acfbsy, o_cu_match_valid,
               o_cu_match_idx, o_cu_drop_cnt, o_cu_rej_cnt
    );

    modport master (
        output i_cu_syn_can_ready, i_cu_rx_message, i_cu_rx_full, i_cu_uaf,
               i_cu_afr_id, i_cu_afr_mask, i_cu_cnt_clr,
        input  o_cu_rx_w_en, o_cu_rx_fifo_w_data, o_cu_acfbsy, o_cu_match_valid,
               o_cu_match_idx, o_cu_drop_cnt, o_cu_rej_cnt
    );
endinterface

// File: rtl/can_acf_multi_cu.sv
// CAN RX acceptance filter control unit: NUM_FILT ID/mask filters with
// lowest-index priority, bypass, FIFO-full stalling and saturating counters.
module can_acf_multi_cu #(
    parameter int MSG_W    = 128,
    parameter int NUM_FILT = 4,
    parameter int ID_LSB   = 3,
    parameter int IDE_POS  = 2,
    parameter int CNT_W    = 8
) (
    input  logic               i_cu_sys_clk,
    input  logic               i_cu_reset,
    can_acf_multi_cu_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_r;
    logic [MSG_W-1:0]   msg_r;
    logic               match_flag_r;
    logic [3:0]         idx_r;
    logic               acfbsy_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic [CNT_W-1:0]   rej_cnt_r;

    logic [29:0]         key_s;
    logic [NUM_FILT-1:0] hit_s;
    logic [3:0]          hit_idx_s;
    logic                any_hit_s;
    logic                bypass_s;
    logic                drop_inc_s;
    logic                rej_inc_s;
    logic                w_en_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Filter bank: scanning from the top down leaves the lowest hitting index.
    always_comb begin
        key_s     = {msg_r[IDE_POS], msg_r[ID_LSB+28:ID_LSB]};
        hit_s     = '0;
        hit_idx_s = 4'd0;
        for (int k = NUM_FILT - 1; k >= 0; k--) begin
            if (bus.i_cu_uaf[k] &&
                (((key_s ^ bus.i_cu_afr_id[30*k +: 30]) & bus.i_cu_afr_mask[30*k +: 30]) == 30'd0)) begin
                hit_s[k]  = 1'b1;
                hit_idx_s = 4'(k);
            end else begin
                hit_s[k]  = 1'b0;
            end
        end
        any_hit_s  = |hit_s;
        bypass_s   = (bus.i_cu_uaf == {NUM_FILT{1'b0}});
        drop_inc_s = bus.i_cu_syn_can_ready && (state_r != ST_IDLE);
        rej_inc_s  = (state_r == ST_COMPARE) && !bypass_s && !any_hit_s;
        w_en_s     = (state_r == ST_WRITE) && !bus.i_cu_rx_full;
    end

    // Control FSM; msg_r doubles as the FIFO write-data register.
    always_ff @(posedge i_cu_sys_clk) begin
        if (i_cu_reset) begin
            state_r      <= ST_IDLE;
            msg_r        <= '0;
            match_flag_r <= 1'b0;
            idx_r        <= 4'd0;
            acfbsy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_cu_syn_can_ready) begin
                        msg_r    <= bus.i_cu_rx_message;
                        state_r  <= ST_COMPARE;
                        acfbsy_r <= 1'b1;
                    end else begin
                        acfbsy_r <= 1'b0;
                    end
                end
                ST_COMPARE: begin
                    if (bypass_s) begin
                        match_flag_r <= 1'b0;
                        idx_r        <= 4'd0;
                        state_r      <= ST_WRITE;
                    end else if (any_hit_s) begin
                        match_flag_r <= 1'b1;
                        idx_r        <= hit_idx_s;
                        state_r      <= ST_WRITE;
                    end else begin
                        state_r      <= ST_IDLE;
                        acfbsy_r     <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!bus.i_cu_rx_full) begin
                        state_r  <= ST_IDLE;
                        acfbsy_r <= 1'b0;
                    end else begin
                        state_r  <= ST_WRITE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    acfbsy_r <= 1'b0;
                end
            endcase
        end
    end

    // Drop/reject counters: reset beats clear, clear beats increment.
    always_ff @(posedge i_cu_sys_clk) begin
        if (i_cu_reset) begin
            drop_cnt_r <= '0;
            rej_cnt_r  <= '0;
        end else if (bus.i_cu_cnt_clr) begin
            drop_cnt_r <= '0;
            rej_cnt_r  <= '0;
        end else begin
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (rej_inc_s) begin
                rej_cnt_r <= sat_inc(rej_cnt_r);
            end else begin
                rej_cnt_r <= rej_cnt_r;
            end
        end
    end

    // The write strobe follows the live full flag so a stall releases in the same cycle.
    assign bus.o_cu_rx_w_en        = w_en_s;
    assign bus.o_cu_match_valid    = w_en_s && match_flag_r;
    assign bus.o_cu_match_idx      = (w_en_s && match_flag_r) ? idx_r : 4'd0;
    assign bus.o_cu_rx_fifo_w_data = msg_r;
    assign bus.o_cu_acfbsy         = acfbsy_r;
    assign bus.o_cu_drop_cnt       = drop_cnt_r;
    assign bus.o_cu_rej_cnt        = rej_cnt_r;

endmodule

// File: tb/tb_can_acf_multi_cu.sv
// Directed bench for can_acf_multi_cu with a scoreboard of expected FIFO writes.
module tb_can_acf_multi_cu;
    localparam int MSG_W   = 128;
    localparam int ID_LSB  = 3;
    localparam int IDE_POS = 2;
    localparam logic [29:0] ALL1 = 30'h3FFF_FFFF;

    typedef struct {
        logic [MSG_W-1:0] data;
        logic             valid;
        logic [3:0]       idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    can_acf_multi_cu_if bus ();

    can_acf_multi_cu dut (
        .i_cu_sys_clk (clk),
        .i_cu_reset   (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic ide, input logic [28:0] id);
        logic [MSG_W-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        m[ID_LSB +: 29] = id;
        m[IDE_POS]      = ide;
        return m;
    endfunction

    task automatic set_filt(input int k, input logic [29:0] id, input logic [29:0] mask);
        bus.i_cu_afr_id[30*k +: 30]   = id;
        bus.i_cu_afr_mask[30*k +: 30] = mask;
    endtask

    task automatic push_exp(input logic [MSG_W-1:0] m, input logic v, input logic [3:0] i);
        exp_t e;
        e.data  = m;
        e.valid = v;
        e.idx   = i;
        exp_q.push_back(e);
    endtask

    // Ready pulse in cycle t; returns in cycle t+1 (COMPARE).
    task automatic pulse(input logic [MSG_W-1:0] m);
        bus.i_cu_rx_message    = m;
        bus.i_cu_syn_can_ready = 1'b1;
        tick();
        bus.i_cu_syn_can_ready = 1'b0;
    endtask

    task automatic send_hit(input string tag, input logic [MSG_W-1:0] m, input logic v, input logic [3:0] i);
        push_exp(m, v, i);
        pulse(m);
        check({tag, "_cmp_busy"}, 128'(bus.o_cu_acfbsy), 128'(1'b1));
        check({tag, "_cmp_data"}, 128'(bus.o_cu_rx_fifo_w_data), 128'(m));
        check({tag, "_cmp_wen"}, 128'(bus.o_cu_rx_w_en), 128'(1'b0));
        tick();
        check({tag, "_t2_wen"}, 128'(bus.o_cu_rx_w_en), 128'(1'b1));
        tick();
        check({tag, "_idle_busy"}, 128'(bus.o_cu_acfbsy), 128'(1'b0));
        check({tag, "_hold_data"}, 128'(bus.o_cu_rx_fifo_w_data), 128'(m));
    endtask

    task automatic send_rej(input string tag, input logic [MSG_W-1:0] m, input logic [7:0] rej);
        int wr0;
        wr0 = wr_count;
        pulse(m);
        tick();
        check({tag, "_rej_cnt"}, 128'(bus.o_cu_rej_cnt), 128'(rej));
        check({tag, "_busy"}, 128'(bus.o_cu_acfbsy), 128'(1'b0));
        tick();
        check({tag, "_no_wen"}, 128'(wr_count), 128'(wr0));
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.o_cu_rx_w_en === 1'b1) begin
            wr_count++;
            check("wen_expected", 128'(exp_q.size() != 0), 128'(1'b1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_data", 128'(bus.o_cu_rx_fifo_w_data), 128'(mon_e.data));
                check("wr_match_valid", 128'(bus.o_cu_match_valid), 128'(mon_e.valid));
                check("wr_match_idx", 128'(bus.o_cu_match_idx), 128'(mon_e.idx));
            end
        end
    end

    initial begin
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] m2;
        int wr0;

        bus.i_cu_syn_can_ready = 1'b0;
        bus.i_cu_rx_message    = '0;
        bus.i_cu_rx_full       = 1'b0;
        bus.i_cu_uaf           = 4'b0000;
        bus.i_cu_afr_id        = '0;
        bus.i_cu_afr_mask      = {4{ALL1}};
        bus.i_cu_cnt_clr       = 1'b0;
        repeat (3) tick();
        check("rst_wen", 128'(bus.o_cu_rx_w_en), 128'(1'b0));
        check("rst_data", 128'(bus.o_cu_rx_fifo_w_data), 128'(0));
        check("rst_busy", 128'(bus.o_cu_acfbsy), 128'(1'b0));
        check("rst_mv", 128'(bus.o_cu_match_valid), 128'(1'b0));
        check("rst_idx", 128'(bus.o_cu_match_idx), 128'(0));
        check("rst_drop", 128'(bus.o_cu_drop_cnt), 128'(0));
        check("rst_rej", 128'(bus.o_cu_rej_cnt), 128'(0));
        rst = 1'b0;
        tick();

        // Single hit on filter 2
        set_filt(2, {1'b0, 29'h123}, ALL1);
        bus.i_cu_uaf = 4'b0100;
        send_hit("single", mk(1'b0, 29'h123), 1'b1, 4'd2);

        // Priority: filter1 accepts everything, filter3 exact
        set_filt(1, 30'h0, 30'h0);
        set_filt(3, {1'b0, 29'h0ABCDE}, ALL1);
        bus.i_cu_uaf = 4'b1010;
        send_hit("prio", mk(1'b0, 29'h0ABCDE), 1'b1, 4'd1);
        send_hit("prio_flip", mk(1'b0, 29'h0ABCDE ^ 29'h20), 1'b1, 4'd1);
        bus.i_cu_uaf = 4'b1000;
        send_hit("f3_only", mk(1'b0, 29'h0ABCDE), 1'b1, 4'd3);
        send_rej("ide_mismatch", mk(1'b1, 29'h0ABCDE), 8'd1);

        // Filter1 (mask 0) disabled must not hit
        bus.i_cu_uaf = 4'b0100;
        send_rej("disabled_mask0", mk(1'b0, 29'h456), 8'd2);
        set_filt(0, {1'b0, 29'h7}, ALL1);
        bus.i_cu_uaf = 4'b0001;
        send_rej("f0_reject", mk(1'b0, 29'h8), 8'd3);

        // Bypass
        bus.i_cu_uaf = 4'b0000;
        send_hit("bypass", mk(1'b1, 29'h1FFF_FFFF), 1'b0, 4'd0);

        // Config is taken in the COMPARE cycle only
        bus.i_cu_uaf = 4'b0001;
        m = mk(1'b0, 29'h9);
        push_exp(m, 1'b1, 4'd0);
        pulse(m);
        set_filt(0, {1'b0, 29'h9}, ALL1);
        tick();
        set_filt(0, {1'b0, 29'h7}, ALL1);
        check("cfg_sample_wen", 128'(bus.o_cu_rx_w_en), 128'(1'b1));
        tick();

        // Backpressure with a drop during the stall
        bus.i_cu_rx_full = 1'b1;
        m  = mk(1'b0, 29'h7);
        m2 = mk(1'b0, 29'h7);
        push_exp(m, 1'b1, 4'd0);
        pulse(m);
        tick();
        for (int c = 2; c <= 6; c++) begin
            check("bp_wen", 128'(bus.o_cu_rx_w_en), 128'(1'b0));
            check("bp_busy", 128'(bus.o_cu_acfbsy), 128'(1'b1));
            check("bp_data", 128'(bus.o_cu_rx_fifo_w_data), 128'(m));
            bus.i_cu_syn_can_ready = (c == 4);
            bus.i_cu_rx_message    = m2;
            tick();
        end
        bus.i_cu_rx_full = 1'b0;
        #1;
        check("bp_release_wen", 128'(bus.o_cu_rx_w_en), 128'(1'b1));
        tick();
        check("bp_drop_cnt", 128'(bus.o_cu_drop_cnt), 128'(1));
        check("bp_idle", 128'(bus.o_cu_acfbsy), 128'(1'b0));

        // Drop counter saturation
        bus.i_cu_rx_full = 1'b1;
        m = mk(1'b0, 29'h7);
        push_exp(m, 1'b1, 4'd0);
        pulse(m);
        tick();
        bus.i_cu_rx_message    = m2;
        bus.i_cu_syn_can_ready = 1'b1;
        repeat (300) tick();
        bus.i_cu_syn_can_ready = 1'b0;
        check("drop_sat", 128'(bus.o_cu_drop_cnt), 128'(8'd255));
        tick();
        check("drop_sat_hold", 128'(bus.o_cu_drop_cnt), 128'(8'd255));
        check("rej_unchanged", 128'(bus.o_cu_rej_cnt), 128'(3));
        bus.i_cu_rx_full = 1'b0;
        tick();

        // Clear beats a same-cycle drop increment
        bus.i_cu_rx_full = 1'b1;
        m = mk(1'b0, 29'h7);
        push_exp(m, 1'b1, 4'd0);
        pulse(m);
        tick();
        bus.i_cu_syn_can_ready = 1'b1;
        bus.i_cu_cnt_clr       = 1'b1;
        tick();
        bus.i_cu_syn_can_ready = 1'b0;
        bus.i_cu_cnt_clr       = 1'b0;
        check("clr_drop", 128'(bus.o_cu_drop_cnt), 128'(0));
        check("clr_rej", 128'(bus.o_cu_rej_cnt), 128'(0));
        bus.i_cu_rx_full = 1'b0;
        tick();

        // Clear beats a same-cycle reject increment
        pulse(mk(1'b0, 29'h8));
        bus.i_cu_cnt_clr = 1'b1;
        tick();
        bus.i_cu_cnt_clr = 1'b0;
        check("clr_rej_inc", 128'(bus.o_cu_rej_cnt), 128'(0));
        tick();
        send_rej("after_clr", mk(1'b0, 29'h8), 8'd1);

        // Reset during a stalled write aborts it
        bus.i_cu_rx_full = 1'b1;
        pulse(mk(1'b0, 29'h7));
        tick();
        check("mid_busy", 128'(bus.o_cu_acfbsy), 128'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_wen", 128'(bus.o_cu_rx_w_en), 128'(1'b0));
        check("mrst_busy", 128'(bus.o_cu_acfbsy), 128'(1'b0));
        check("mrst_data", 128'(bus.o_cu_rx_fifo_w_data), 128'(0));
        check("mrst_mv", 128'(bus.o_cu_match_valid), 128'(1'b0));
        check("mrst_idx", 128'(bus.o_cu_match_idx), 128'(0));
        check("mrst_rej", 128'(bus.o_cu_rej_cnt), 128'(0));
        check("mrst_drop", 128'(bus.o_cu_drop_cnt), 128'(0));
        wr0 = wr_count;
        bus.i_cu_rx_full = 1'b0;
        repeat (5) tick();
        check("mrst_no_wen", 128'(wr_count), 128'(wr0));
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
